// File: rtl/fpu_issue_ctrl_pkg.sv
// Shared FPU types, NaN constants and issue-controller state encoding.
// Imported by the issue controller and its bench.
package fpu_issue_ctrl_pkg;

  typedef logic [15:0] fp16_t;
  typedef logic [31:0] fp32_t;
  typedef logic [63:0] fp64_t;

  localparam fp16_t NAN16 = 16'h7E00;
  localparam fp32_t NAN32 = 32'h7FC0_0000;
  localparam fp64_t NAN64 = 64'h7FF8_0000_0000_0000;

  typedef enum logic [1:0] {
    FPU_ADD,
    FPU_SUB,
    FPU_MUL,
    FPU_DIV
  } fpuOp_t;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } condCode_t;

  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } statusFlag_t;

  typedef struct packed {
    logic lt;
    logic eq;
    logic gt;
    logic un;
  } fpuComp_t;

  typedef enum logic [2:0] {
    IDLE,
    EXEC,
    START,
    WAIT,
    RESP
  } issueState_t;

  localparam statusFlag_t TIMEOUT_FLAGS = '{
    nv: 1'b1,
    default: 1'b0
  };

  // Quiet NaN for a format, zero-extended to 64 bits.
  function automatic logic [63:0] nan_bits(input int w);
    case (w)
      64:      return NAN64;
      32:      return {32'b0, NAN32};
      default: return {48'b0, NAN16};
    endcase
  endfunction

endpackage

// File: rtl/fpu_issue_timeout.sv
// Wait-cycle counter: clear, count-enable, expired at LIMIT-1.
// Ports: clock, reset, clear, enable -> expired.
module fpu_issue_timeout #(
  parameter int LIMIT = 64,
  parameter int W     = $clog2(LIMIT) + 1
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] count;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Requester-side FPU driver: one op at a time, req/rsp handshakes.
// Ports: req channel, rsp channel, fpu operand/op/start, fpu results.
module fpu_issue_ctrl
  import fpu_issue_ctrl_pkg::*;
#(
  parameter type FP_T           = fp16_t,
  parameter int  TAG_W          = 4,
  parameter int  TIMEOUT_CYCLES = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             reqValid,
  output logic             reqReady,
  input  fpuOp_t           reqOp,
  input  FP_T              reqA,
  input  FP_T              reqB,
  input  logic [TAG_W-1:0] reqTag,
  output logic             rspValid,
  input  logic             rspReady,
  output FP_T              rspResult,
  output condCode_t        rspCondCodes,
  output statusFlag_t      rspStatusFlags,
  output fpuComp_t         rspComps,
  output logic [TAG_W-1:0] rspTag,
  output logic             rspTimeout,
  output FP_T              fpuIn1,
  output FP_T              fpuIn2,
  output fpuOp_t           op,
  output logic             start,
  input  FP_T              fpuOut,
  input  logic             mulDone,
  input  logic             divDone,
  input  condCode_t        condCodes,
  input  statusFlag_t      statusFlags,
  input  fpuComp_t         comps
);

  localparam int FW = $bits(FP_T);
  localparam logic [63:0] NAN_RAW = nan_bits(FW);
  localparam FP_T NAN_V = FP_T'(NAN_RAW[FW-1:0]);

  issueState_t state, state_nxt;
  logic accept, done, expired;
  logic cap_fpu, cap_to, cnt_clr, cnt_en;
  logic [TAG_W-1:0] tag;

  // Handshake outputs are gated so they read 0 while reset is held.
  assign reqReady = (state == IDLE) && !reset;
  assign rspValid = (state == RESP) && !reset;
  assign start    = (state == START) && !reset;
  assign accept   = reqValid && reqReady;
  assign rspTag   = tag;

  // Only the done that belongs to the issued op counts.
  assign done = (op == FPU_MUL && mulDone)
             || (op == FPU_DIV && divDone);

  fpu_issue_timeout #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clock   (clock),
    .reset   (reset),
    .clear   (cnt_clr),
    .enable  (cnt_en),
    .expired (expired)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cap_fpu   = 1'b0;
    cap_to    = 1'b0;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (reqOp == FPU_MUL || reqOp == FPU_DIV) begin
            state_nxt = START;
          end else begin
            state_nxt = EXEC;
          end
        end
      end
      EXEC: begin
        cap_fpu   = 1'b1;
        state_nxt = RESP;
      end
      START: begin
        cnt_clr   = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        cnt_en = 1'b1;
        if (done) begin
          cap_fpu   = 1'b1;
          state_nxt = RESP;
        end else if (expired) begin
          cap_to    = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (rspReady) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fpuIn1         <= '0;
      fpuIn2         <= '0;
      op             <= FPU_ADD;
      tag            <= '0;
      rspResult      <= '0;
      rspCondCodes   <= '0;
      rspStatusFlags <= '0;
      rspComps       <= '0;
      rspTimeout     <= 1'b0;
    end else begin
      if (accept) begin
        fpuIn1 <= reqA;
        fpuIn2 <= reqB;
        op     <= reqOp;
        tag    <= reqTag;
      end
      if (cap_fpu) begin
        rspResult      <= fpuOut;
        rspCondCodes   <= condCodes;
        rspStatusFlags <= statusFlags;
        rspComps       <= comps;
        rspTimeout     <= 1'b0;
      end else if (cap_to) begin
        rspResult      <= NAN_V;
        rspCondCodes   <= '0;
        rspStatusFlags <= TIMEOUT_FLAGS;
        rspComps       <= '0;
        rspTimeout     <= 1'b1;
      end
    end
  end

endmodule
